// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg: shared FSM state type and default parameters for mux_arbiter
package mux_arbiter_pkg;
    typedef enum logic {IDLE, GRANT} state_t;
    localparam int NREQ_DEF     = 2;
    localparam int W_DEF        = 8;
    localparam int MAX_HOLD_DEF = 4;
endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting at last+1
// Ports: req (requests), last (previous grantee) -> winner (index), any (some req high)
module rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [$clog2(NREQ)-1:0] winner,
    output logic                    any
);
    localparam int SW = $clog2(NREQ);
    // Scan from farthest to nearest so the nearest asserted request after last wins.
    always_comb begin
        winner = '0;
        for (int i = NREQ; i >= 1; i--)
            if (req[(int'(last) + i) % NREQ]) winner = SW'((int'(last) + i) % NREQ);
    end
    assign any = |req;
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin arbitrated output mux with registered grant and data
// Ports: clk, rst (async active-high), req[NREQ], din[NREQ*W] -> gnt[NREQ], sel, dout[W], dout_valid
// Build option: MUX_ARBITER_HOLD_LIMIT_EN caps a grant at MAX_HOLD beats while others are waiting.
module mux_arbiter import mux_arbiter_pkg::*; #(
    parameter int NREQ     = NREQ_DEF,
    parameter int W        = W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*W-1:0]       din,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] sel,
    output logic [W-1:0]            dout,
    output logic                    dout_valid
);
    localparam int SW = $clog2(NREQ);
    state_t        state;
    logic [SW-1:0] last;
    logic [SW-1:0] winner;
    logic          any;
    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .last   (last),
        .winner (winner),
        .any    (any)
    );
`ifdef MUX_ARBITER_HOLD_LIMIT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt;
    logic          at_limit;
    // Once saturated the counter stays at or above the limit, so the next beat with a waiter releases.
    assign at_limit = (hold_cnt >= HW'(MAX_HOLD - 1)) && |(req & ~gnt);
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            sel        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            last       <= SW'(NREQ - 1);
`ifdef MUX_ARBITER_HOLD_LIMIT_EN
            hold_cnt   <= '0;
`endif
        end else if (state == IDLE) begin
            dout_valid <= 1'b0;
            gnt        <= any ? NREQ'(1) << winner : '0;
            if (any) begin
                state <= GRANT;
                sel   <= winner;
`ifdef MUX_ARBITER_HOLD_LIMIT_EN
                hold_cnt <= '0;
`endif
            end
        end else if (req[sel]) begin
            dout       <= din[int'(sel)*W +: W];
            dout_valid <= 1'b1;
`ifdef MUX_ARBITER_HOLD_LIMIT_EN
            if (hold_cnt != HW'(MAX_HOLD)) hold_cnt <= hold_cnt + HW'(1);
            if (at_limit) begin
                state <= IDLE;
                gnt   <= '0;
                last  <= sel;
            end
`endif
        end else begin
            state      <= IDLE;
            gnt        <= '0;
            dout_valid <= 1'b0;
            last       <= sel;
        end
    end
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: scoreboard bench for mux_arbiter (NREQ=2 modelled, NREQ=4 directed)
module tb_mux_arbiter;
    localparam int MAXH = 4;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req2;
    logic [15:0] din2;
    logic [1:0]  gnt2;
    logic        sel2;
    logic [7:0]  dout2;
    logic        dv2;
    logic [3:0]  req4;
    logic [31:0] din4;
    logic [3:0]  gnt4;
    logic [1:0]  sel4;
    logic [7:0]  dout4;
    logic        dv4;
    int total = 0;
    int bad = 0;
    typedef struct packed {
        logic [1:0] gnt;
        logic       sel;
        logic [7:0] dout;
        logic       dv;
    } exp_t;
    exp_t q[$];
    bit         m_grant;
    logic [1:0] m_gnt;
    int         m_sel;
    logic [7:0] m_dout;
    logic       m_dv;
    int         m_last;
    int         m_hold;
    always #5 clk = ~clk;
    mux_arbiter #(.NREQ(2), .W(8), .MAX_HOLD(MAXH)) u_dut2 (
        .clk(clk), .rst(rst), .req(req2), .din(din2),
        .gnt(gnt2), .sel(sel2), .dout(dout2), .dout_valid(dv2)
    );
    mux_arbiter #(.NREQ(4), .W(8), .MAX_HOLD(MAXH)) u_dut4 (
        .clk(clk), .rst(rst), .req(req4), .din(din4),
        .gnt(gnt4), .sel(sel4), .dout(dout4), .dout_valid(dv4)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        m_grant = 1'b0; m_gnt = '0; m_sel = 0; m_dout = '0; m_dv = 1'b0; m_last = 1; m_hold = 0;
    endtask
    task automatic predict(input logic [1:0] r, input logic [15:0] d);
        bit found;
        bit lim;
        if (!m_grant) begin
            m_dv = 1'b0;
            m_gnt = '0;
            found = 1'b0;
            for (int k = 1; k <= 2; k++) begin
                int i;
                i = (m_last + k) % 2;
                if (!found && r[i]) begin
                    found = 1'b1;
                    m_grant = 1'b1;
                    m_sel = i;
                    m_gnt = 2'b01 << i;
                    m_hold = 0;
                end
            end
        end else if (r[m_sel]) begin
            m_dout = d[m_sel*8 +: 8];
            m_dv = 1'b1;
            lim = (m_hold >= MAXH - 1) && ((r & ~(2'b01 << m_sel)) != 2'b00);
            if (m_hold < MAXH) m_hold++;
`ifdef MUX_ARBITER_HOLD_LIMIT_EN
            if (lim) begin
                m_grant = 1'b0;
                m_gnt = '0;
                m_last = m_sel;
            end
`endif
        end else begin
            m_grant = 1'b0;
            m_gnt = '0;
            m_dv = 1'b0;
            m_last = m_sel;
        end
    endtask
    task automatic cycle2(input logic [1:0] r, input logic [15:0] d);
        exp_t e;
        req2 = r;
        din2 = d;
        predict(r, d);
        e.gnt = m_gnt; e.sel = 1'(m_sel); e.dout = m_dout; e.dv = m_dv;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("gnt2", 32'(gnt2), 32'(e.gnt));
        check("sel2", 32'(sel2), 32'(e.sel));
        check("dout2", 32'(dout2), 32'(e.dout));
        check("dv2", 32'(dv2), 32'(e.dv));
    endtask
    initial begin
        rst = 1'b1; req2 = '0; din2 = '0; req4 = '0; din4 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt2", 32'(gnt2), 0);
        check("rst_sel2", 32'(sel2), 0);
        check("rst_dout2", 32'(dout2), 0);
        check("rst_dv2", 32'(dv2), 0);
        check("rst_gnt4", 32'(gnt4), 0);
        check("rst_sel4", 32'(sel4), 0);
        rst = 1'b0;
        cycle2(2'b11, 16'h3CA5);
        check("first_gnt", 32'(gnt2), 32'h1);
        cycle2(2'b11, 16'h3CA5);
        check("first_dout", 32'(dout2), 32'hA5);
        cycle2(2'b11, 16'h3CA5);
        cycle2(2'b10, 16'h3CA5);
        check("bubble_gnt", 32'(gnt2), 0);
        cycle2(2'b10, 16'h3CA5);
        check("second_gnt", 32'(gnt2), 32'h2);
        cycle2(2'b10, 16'h3CA5);
        check("second_dout", 32'(dout2), 32'h3C);
        for (int i = 0; i < 12; i++) cycle2(2'b11, {8'(i + 8'h40), 8'(i + 8'h10)});
        for (int i = 0; i < 3; i++) cycle2(2'b00, 16'hFFFF);
        req4 = 4'b1010; din4 = 32'hD4C3B2A1;
        cycle2(2'b00, 16'h0);
        check("rr4_gnt_a", 32'(gnt4), 32'h2);
        check("rr4_sel_a", 32'(sel4), 1);
        cycle2(2'b00, 16'h0);
        check("rr4_dout_a", 32'(dout4), 32'hB2);
        check("rr4_dv_a", 32'(dv4), 1);
        req4 = 4'b1000;
        cycle2(2'b00, 16'h0);
        check("rr4_rel_a", 32'(gnt4), 0);
        check("rr4_dv_rel", 32'(dv4), 0);
        req4 = 4'b1010;
        cycle2(2'b00, 16'h0);
        check("rr4_gnt_b", 32'(gnt4), 32'h8);
        check("rr4_sel_b", 32'(sel4), 3);
        cycle2(2'b00, 16'h0);
        check("rr4_dout_b", 32'(dout4), 32'hD4);
        req4 = 4'b0010;
        cycle2(2'b00, 16'h0);
        check("rr4_rel_b", 32'(gnt4), 0);
        req4 = 4'b1010;
        cycle2(2'b00, 16'h0);
        check("rr4_gnt_wrap", 32'(gnt4), 32'h2);
        check("rr4_dout_hold", 32'(dout4), 32'hD4);
        req4 = 4'b0000;
        cycle2(2'b00, 16'h0);
        for (int i = 0; i < 300; i++) cycle2(2'($urandom_range(0, 3)), 16'($urandom));
        cycle2(2'b01, 16'h5A77);
        cycle2(2'b01, 16'h5A77);
        cycle2(2'b01, 16'h5A77);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_gnt", 32'(gnt2), 0);
        check("async_dout", 32'(dout2), 0);
        check("async_dv", 32'(dv2), 0);
        check("async_sel", 32'(sel2), 0);
        rst = 1'b0;
        model_reset();
        cycle2(2'b10, 16'h9966);
        check("post_rst_gnt", 32'(gnt2), 32'h2);
        cycle2(2'b10, 16'h9966);
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        cycle2(2'b11, 16'h1234);
        check("restart_r0", 32'(gnt2), 32'h1);
        for (int i = 0; i < 14; i++) cycle2(2'b11, {8'(i + 8'h80), 8'(i + 8'h20)});
        cycle2(2'b00, 16'h0);
        cycle2(2'b00, 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
